mult_div_unit: RTL

//   Sequential signed multiply/divide unit for the multicycle MIPS datapath. Sits

---
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring, magnitude + sign fix-up)
// unit holding the architectural HI/LO registers of the multicycle MIPS datapath.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: a start_* pulse is accepted only while busy==0 (start_mult wins over
  // start_div); busy stays high until the edge that raises the one-cycle done pulse.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_dz_flag;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;

  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  // Accumulator carries one guard bit so subtracting the most negative multiplicand
  // cannot overflow before the arithmetic shift.
  assign w_m_ext     = {r_m[WIDTH-1], r_m};
  assign w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_m};

  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_mult)     w_next = S_MULT;
        else if (start_div) w_next = (b == '0) ? S_FIN : S_DIV;
      end
      S_MULT:  if (w_last) w_next = S_FIN;
      S_DIV:   if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc      <= '0;
      r_q        <= '0;
      r_q1       <= 1'b0;
      r_m        <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_dz_flag  <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_mult) begin
            r_acc     <= '0;
            r_q       <= a;
            r_q1      <= 1'b0;
            r_m       <= b;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_dz_flag <= 1'b0;
          end else if (start_div) begin
            r_acc     <= '0;
            r_q       <= w_abs_a;
            r_q1      <= 1'b0;
            r_m       <= w_abs_b;
            r_cnt     <= '0;
            r_is_div  <= 1'b1;
            r_dz_flag <= (b == '0);
            r_neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r   <= a[WIDTH-1];
          end
        end
        S_MULT: begin
          {r_acc, r_q, r_q1} <= {w_booth_sum[WIDTH], w_booth_sum, r_q};
          r_cnt <= r_cnt + CW'(1);
        end
        S_DIV: begin
          // Quotient bits shift in from the right as dividend bits leave on the left.
          if (!w_div_trial[WIDTH]) begin
            r_acc <= w_div_trial;
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_div_shift;
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIN: begin
          r_done <= 1'b1;
          if (r_dz_flag) begin
            r_div_zero <= 1'b1;
          end else if (r_is_div) begin
            r_lo <= r_neg_q ? (~r_q + 1'b1) : r_q;
            r_hi <= r_neg_r ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
          end else begin
            r_hi <= r_acc[WIDTH-1:0];
            r_lo <= r_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign dbg_state = r_state;

endmodule
